// File: rtl/osiris_pkg.sv
// osiris_pkg: shared encodings for the Osiris memory-port arbiter.
// Owner one-hot codes, arbitration modes, FSM states (ABORT under MEM_ARB_TIMEOUT_EN).
package osiris_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
`ifdef MEM_ARB_TIMEOUT_EN
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
`else
        ST_OWN1  = 2'd2
`endif
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts cycles of unacknowledged strobe for the arbiter.
// expire is raised in the cycle the count sits at TIMEOUT_CYCLES-1 and is still counting.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // Wait counter: cleared on ack or when no access is owned
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

    assign expire = count_en & (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master Wishbone arbiter (M0 core, M1 UART) for one mem_byte.
// Watchdog abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ARB_MODE       = ARB_FIXED,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [2:0]            m0_funct3_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_stall_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_stall_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [2:0]            s_funct3_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            owner_o
);

    arb_state_t state;
    logic       last;
    logic       req0;
    logic       req1;
    logic       pick1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // last = 1 means M1 was served most recently
    assign pick1 = req1 & (~req0 | (ARB_MODE == ARB_FIXED) | ~last);

`ifdef MEM_ARB_TIMEOUT_EN
    logic       expire;
    logic       busy;
    logic [1:0] err;

    assign busy = |owner_o;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (busy & s_stb_o & ~s_ack_i),
        .clear    (~busy | s_ack_i),
        .expire   (expire)
    );

    assign m0_err_o = err[0];
    assign m1_err_o = err[1];
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    // Ownership FSM: grant in IDLE, hold while owner keeps cyc
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner_o <= OWN_NONE;
            last    <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            err     <= 2'b00;
`endif
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            err <= 2'b00;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        state   <= pick1 ? ST_OWN1 : ST_OWN0;
                        owner_o <= pick1 ? OWN_M1 : OWN_M0;
                    end
                end
                ST_OWN0: begin
                    if (!m0_cyc_i) begin
                        state   <= ST_IDLE;
                        owner_o <= OWN_NONE;
                        last    <= 1'b0;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (expire) begin
                        state   <= ST_ABORT;
                        owner_o <= OWN_NONE;
                        last    <= 1'b0;
                        err     <= OWN_M0;
                    end
`endif
                end
                ST_OWN1: begin
                    if (!m1_cyc_i) begin
                        state   <= ST_IDLE;
                        owner_o <= OWN_NONE;
                        last    <= 1'b1;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (expire) begin
                        state   <= ST_ABORT;
                        owner_o <= OWN_NONE;
                        last    <= 1'b1;
                        err     <= OWN_M1;
                    end
`endif
                end
`ifdef MEM_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    state <= ST_IDLE;
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    owner_o <= OWN_NONE;
                end
            endcase
        end
    end

    // Slave side is a pure mux of the owner; all zero when nobody owns
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_funct3_o = 3'b000;
        unique case (1'b1)
            owner_o[0]: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_funct3_o = m0_funct3_i;
            end
            owner_o[1]: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_funct3_o = FUNCT3_WORD;
            end
            default: begin
            end
        endcase
    end

    assign m0_ack_o = owner_o[0] & s_ack_i;
    assign m1_ack_o = owner_o[1] & s_ack_i;
    assign m0_dat_o = owner_o[0] ? s_dat_i : '0;
    assign m1_dat_o = owner_o[1] ? s_dat_i : '0;

    // Stall is held low while reset is asserted
    assign m0_stall_o = rst & req0 & ~owner_o[0];
    assign m1_stall_o = rst & req1 & ~owner_o[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter.
// Instance 0 runs fixed priority, instance 1 round-robin; both share stimulus.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [2:0]    m0_funct3_i;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    logic [DW-1:0] m0_dat_o [2];
    logic          m0_ack_o [2];
    logic          m0_err_o [2];
    logic          m0_stall_o [2];
    logic [DW-1:0] m1_dat_o [2];
    logic          m1_ack_o [2];
    logic          m1_err_o [2];
    logic          m1_stall_o [2];
    logic          s_cyc_o [2];
    logic          s_stb_o [2];
    logic          s_we_o [2];
    logic [AW-1:0] s_adr_o [2];
    logic [DW-1:0] s_dat_o [2];
    logic [2:0]    s_funct3_o [2];
    logic [1:0]    owner_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .DATA_WIDTH     (DW),
            .ADDR_WIDTH     (AW),
            .ARB_MODE       (g),
            .TIMEOUT_CYCLES (TO)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .m0_cyc_i    (m0_cyc_i),
            .m0_stb_i    (m0_stb_i),
            .m0_we_i     (m0_we_i),
            .m0_adr_i    (m0_adr_i),
            .m0_dat_i    (m0_dat_i),
            .m0_funct3_i (m0_funct3_i),
            .m0_dat_o    (m0_dat_o[g]),
            .m0_ack_o    (m0_ack_o[g]),
            .m0_err_o    (m0_err_o[g]),
            .m0_stall_o  (m0_stall_o[g]),
            .m1_cyc_i    (m1_cyc_i),
            .m1_stb_i    (m1_stb_i),
            .m1_we_i     (m1_we_i),
            .m1_adr_i    (m1_adr_i),
            .m1_dat_i    (m1_dat_i),
            .m1_dat_o    (m1_dat_o[g]),
            .m1_ack_o    (m1_ack_o[g]),
            .m1_err_o    (m1_err_o[g]),
            .m1_stall_o  (m1_stall_o[g]),
            .s_cyc_o     (s_cyc_o[g]),
            .s_stb_o     (s_stb_o[g]),
            .s_we_o      (s_we_o[g]),
            .s_adr_o     (s_adr_o[g]),
            .s_dat_o     (s_dat_o[g]),
            .s_funct3_o  (s_funct3_o[g]),
            .s_dat_i     (s_dat_i),
            .s_ack_i     (s_ack_i),
            .owner_o     (owner_o[g])
        );
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_adr_i = '0; m0_dat_i = '0; m0_funct3_i = 3'b000;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_adr_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 0;
        step();
        step();
        rst = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
        step();
        step();
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (owner_o[g] !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_owner dut%0d got %b want 00", g, owner_o[g]);
            end
            n_cmp++;
            if ({s_cyc_o[g], s_stb_o[g], s_we_o[g], s_funct3_o[g]} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_s_ctl dut%0d got %b want 0", g,
                         {s_cyc_o[g], s_stb_o[g], s_we_o[g], s_funct3_o[g]});
            end
            n_cmp++;
            if ({s_adr_o[g], s_dat_o[g]} !== 64'h0) begin
                n_bad++;
                $display("FAIL reset_s_data dut%0d got %h want 0", g, {s_adr_o[g], s_dat_o[g]});
            end
            n_cmp++;
            if ({m0_stall_o[g], m1_stall_o[g], m0_ack_o[g], m1_ack_o[g],
                 m0_err_o[g], m1_err_o[g]} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_m_ctl dut%0d got %b want 000000", g,
                         {m0_stall_o[g], m1_stall_o[g], m0_ack_o[g], m1_ack_o[g],
                          m0_err_o[g], m1_err_o[g]});
            end
        end
        rst = 1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({m0_stall_o[g], m1_stall_o[g]} !== 2'b11) begin
                n_bad++;
                $display("FAIL release_stall dut%0d got %b want 11", g,
                         {m0_stall_o[g], m1_stall_o[g]});
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_fixed_priority;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], s_stb_o[0], m0_stall_o[0], s_adr_o[0]} !== {2'b10, 2'b11, 32'h20}) begin
            n_bad++;
            $display("FAIL fixed_grant got own=%b stb=%b stall=%b adr=%h want 10 1 1 20",
                     owner_o[0], s_stb_o[0], m0_stall_o[0], s_adr_o[0]);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            n_cmp++;
            if ({owner_o[0], m0_stall_o[0]} !== 3'b101) begin
                n_bad++;
                $display("FAIL fixed_hold k=%0d got own=%b stall=%b want 10 1",
                         k, owner_o[0], m0_stall_o[0]);
            end
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], m0_stall_o[0], s_cyc_o[0]} !== 4'b0010) begin
            n_bad++;
            $display("FAIL fixed_dead got own=%b stall=%b cyc=%b want 00 1 0",
                     owner_o[0], m0_stall_o[0], s_cyc_o[0]);
        end
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], m0_stall_o[0], s_adr_o[0]} !== {3'b010, 32'h10}) begin
            n_bad++;
            $display("FAIL fixed_handover got own=%b stall=%b adr=%h want 01 0 10",
                     owner_o[0], m0_stall_o[0], s_adr_o[0]);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100 + r;
            m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200 + r;
            step();
            #1;
            exp = (r % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (owner_o[1] !== exp) begin
                n_bad++;
                $display("FAIL rr_round%0d got %b want %b", r, owner_o[1], exp);
            end
            n_cmp++;
            if (owner_o[0] !== 2'b10) begin
                n_bad++;
                $display("FAIL rr_fixed_round%0d got %b want 10", r, owner_o[0]);
            end
            idle_inputs();
            step();
            step();
        end
    endtask

    task automatic test_lock;
        logic [31:0] v;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200; m0_funct3_i = 3'b001;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h300;
        m1_dat_i = 32'hA5A5_0001;
        step();
        for (int b = 1; b <= 3; b++) begin
            v = 32'hA5A5_0000 + b;
            m1_dat_i = v;
            s_dat_i = $urandom;
            s_ack_i = 1;
            #1;
            n_cmp++;
            if ({s_dat_o[0], s_funct3_o[0], s_we_o[0]} !== {v, 3'b010, 1'b1}) begin
                n_bad++;
                $display("FAIL lock_beat%0d got dat=%h f3=%b we=%b want %h 010 1",
                         b, s_dat_o[0], s_funct3_o[0], s_we_o[0], v);
            end
            n_cmp++;
            if ({m1_ack_o[0], m0_ack_o[0], m0_stall_o[0], m1_dat_o[0]} !==
                {3'b101, s_dat_i}) begin
                n_bad++;
                $display("FAIL lock_ack%0d got a1=%b a0=%b st0=%b d1=%h want 1 0 1 %h", b,
                         m1_ack_o[0], m0_ack_o[0], m0_stall_o[0], m1_dat_o[0], s_dat_i);
            end
            step();
        end
        s_ack_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], s_funct3_o[0]} !== 5'b00000) begin
            n_bad++;
            $display("FAIL lock_release got own=%b f3=%b want 00 000", owner_o[0], s_funct3_o[0]);
        end
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], s_funct3_o[0], s_adr_o[0]} !== {5'b01001, 32'h200}) begin
            n_bad++;
            $display("FAIL lock_m0_after got own=%b f3=%b adr=%h want 01 001 200",
                     owner_o[0], s_funct3_o[0], s_adr_o[0]);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_watchdog;
        int errs;
        logic exp_err;
        logic exp_cyc;
        errs = 0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
        step();
        #1;
        n_cmp++;
        if ({owner_o[0], s_stb_o[0]} !== 3'b011) begin
            n_bad++;
            $display("FAIL wd_grant got own=%b stb=%b want 01 1", owner_o[0], s_stb_o[0]);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= TO + 1; c++) begin
            step();
            #1;
            exp_err = (c == TO);
            exp_cyc = (c < TO);
            errs += int'(m0_err_o[0]);
            n_cmp++;
            if ({m0_err_o[0], s_cyc_o[0], m1_err_o[0]} !== {exp_err, exp_cyc, 1'b0}) begin
                n_bad++;
                $display("FAIL wd_cycle%0d got err=%b cyc=%b err1=%b want %b %b 0",
                         c, m0_err_o[0], s_cyc_o[0], m1_err_o[0], exp_err, exp_cyc);
            end
        end
        n_cmp++;
        if (errs !== 1) begin
            n_bad++;
            $display("FAIL wd_err_count got %0d want 1", errs);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            step();
            #1;
            errs += int'(m0_err_o[0]) + int'(m1_err_o[0]);
            exp_cyc = 1'b1;
            n_cmp++;
            if ({s_cyc_o[0], m0_err_o[0]} !== {exp_cyc, 1'b0}) begin
                n_bad++;
                $display("FAIL wd_hold%0d got cyc=%b err=%b want 1 0", c, s_cyc_o[0], m0_err_o[0]);
            end
        end
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL wd_err_count got %0d want 0", errs);
        end
`endif
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h55; m1_dat_i = 32'h1234;
        step();
        #1;
        n_cmp++;
        if (owner_o[0] !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_own got %b want 10", owner_o[0]);
        end
        s_ack_i = 1;
        s_dat_i = 32'hCAFE_F00D;
        rst = 0;
        step();
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({owner_o[g], s_cyc_o[g], s_stb_o[g], s_we_o[g]} !== 5'b0) begin
                n_bad++;
                $display("FAIL rstmid_ctl dut%0d got own=%b cyc=%b stb=%b we=%b want 0",
                         g, owner_o[g], s_cyc_o[g], s_stb_o[g], s_we_o[g]);
            end
            n_cmp++;
            if ({s_adr_o[g], s_dat_o[g], m1_dat_o[g], m1_ack_o[g], m1_stall_o[g]} !== 98'b0) begin
                n_bad++;
                $display("FAIL rstmid_data dut%0d got adr=%h dat=%h d1=%h ack=%b stall=%b want 0",
                         g, s_adr_o[g], s_dat_o[g], m1_dat_o[g], m1_ack_o[g], m1_stall_o[g]);
            end
        end
        rst = 1;
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_spurious_ack;
        do_reset();
        s_ack_i = 1;
        s_dat_i = 32'hDEAD_BEEF;
        for (int t = 0; t < 2; t++) begin
            #1;
            for (int g = 0; g < 2; g++) begin
                n_cmp++;
                if ({m0_ack_o[g], m1_ack_o[g], m0_dat_o[g], m1_dat_o[g]} !== 66'b0) begin
                    n_bad++;
                    $display("FAIL spurious_ack t%0d dut%0d got a0=%b a1=%b d0=%h d1=%h want 0",
                             t, g, m0_ack_o[g], m1_ack_o[g], m0_dat_o[g], m1_dat_o[g]);
                end
            end
            step();
        end
        s_ack_i = 0;
        step();
    endtask

    task automatic test_random;
        int          own [2];
        int          last [2];
        bit          act [2];
        int          beats [2];
        bit          acked [2];
        logic [31:0] adr [2];
        logic [31:0] dat [2];
        bit          we [2];
        logic [2:0]  f3;
        int          nack_run;
        bit          r0, r1, c0, c1, ack;
        logic [1:0]  e_own;
        logic [31:0] e_adr;
        logic [2:0]  e_f3;
        logic [3:0]  e_hs;
        logic [31:0] e_d0, e_d1;
        do_reset();
        for (int g = 0; g < 2; g++) begin
            own[g] = -1;
            last[g] = 1;
            act[g] = 0;
            beats[g] = 0;
            acked[g] = 0;
        end
        f3 = 3'b000;
        nack_run = 0;
        for (int cy = 0; cy < 500; cy++) begin
            for (int x = 0; x < 2; x++) begin
                if (!act[x]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        act[x] = 1;
                        beats[x] = $urandom_range(1, 3);
                        adr[x] = $urandom;
                        dat[x] = $urandom;
                        we[x] = 1'($urandom_range(0, 1));
                        if (x == 0) f3 = 3'($urandom_range(0, 7));
                    end
                end else if (acked[x]) begin
                    beats[x]--;
                    if (beats[x] == 0) begin
                        act[x] = 0;
                    end else begin
                        adr[x] = $urandom;
                        dat[x] = $urandom;
                    end
                end
            end
            m0_cyc_i = act[0]; m0_stb_i = act[0]; m0_we_i = we[0];
            m0_adr_i = adr[0]; m0_dat_i = dat[0]; m0_funct3_i = f3;
            m1_cyc_i = act[1]; m1_stb_i = act[1]; m1_we_i = we[1];
            m1_adr_i = adr[1]; m1_dat_i = dat[1];
            ack = (nack_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            nack_run = ack ? 0 : nack_run + 1;
            s_ack_i = ack;
            s_dat_i = $urandom;
            #1;
            for (int g = 0; g < 2; g++) begin
                e_own = (own[g] < 0) ? 2'b00 : (own[g] == 0 ? 2'b01 : 2'b10);
                e_adr = (own[g] == 0) ? adr[0] : (own[g] == 1 ? adr[1] : 32'h0);
                e_f3 = (own[g] == 0) ? f3 : (own[g] == 1 ? 3'b010 : 3'b000);
                e_hs = {own[g] == 0 && ack, own[g] == 1 && ack,
                        act[0] && own[g] != 0, act[1] && own[g] != 1};
                e_d0 = (own[g] == 0) ? s_dat_i : 32'h0;
                e_d1 = (own[g] == 1) ? s_dat_i : 32'h0;
                n_cmp++;
                if (owner_o[g] !== e_own) begin
                    n_bad++;
                    $display("FAIL rnd_owner cy%0d dut%0d got %b want %b", cy, g, owner_o[g], e_own);
                end
                n_cmp++;
                if ({s_adr_o[g], s_funct3_o[g]} !== {e_adr, e_f3}) begin
                    n_bad++;
                    $display("FAIL rnd_slave cy%0d dut%0d got %h/%b want %h/%b",
                             cy, g, s_adr_o[g], s_funct3_o[g], e_adr, e_f3);
                end
                n_cmp++;
                if ({m0_ack_o[g], m1_ack_o[g], m0_stall_o[g], m1_stall_o[g]} !== e_hs) begin
                    n_bad++;
                    $display("FAIL rnd_handshake cy%0d dut%0d got %b want %b", cy, g,
                             {m0_ack_o[g], m1_ack_o[g], m0_stall_o[g], m1_stall_o[g]}, e_hs);
                end
                n_cmp++;
                if ({m0_dat_o[g], m1_dat_o[g]} !== {e_d0, e_d1}) begin
                    n_bad++;
                    $display("FAIL rnd_rdata cy%0d dut%0d got %h/%h want %h/%h",
                             cy, g, m0_dat_o[g], m1_dat_o[g], e_d0, e_d1);
                end
            end
            r0 = act[0]; r1 = act[1]; c0 = act[0]; c1 = act[1];
            acked[0] = (own[0] == 0) && ack;
            acked[1] = (own[0] == 1) && ack;
            step();
            for (int g = 0; g < 2; g++) begin
                if (own[g] < 0) begin
                    if (r0 && r1) own[g] = (g == 0) ? 1 : (last[g] == 1 ? 0 : 1);
                    else if (r1) own[g] = 1;
                    else if (r0) own[g] = 0;
                end else if (!(own[g] == 0 ? c0 : c1)) begin
                    last[g] = own[g];
                    own[g] = -1;
                end
            end
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_watchdog();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master, one-slave Wishbone arbiter placed in front of each `mem_byte` instance in the Osiris top level. It replaces the static `i_select_mem` steering with registered, cycle-accurate ownership. Master 0 is the core data/fetch port and master 1 is the UART bridge. A master keeps ownership for as long as it holds `cyc`, and the losing master sees its bus stalled. A compile-time watchdog can abort a slave access that never acknowledges.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width, all ports.
- `ADDR_WIDTH`, 32: address width, all ports (passed through unchanged).
- `ARB_MODE`, 0: 0 = fixed priority (M1/UART wins), 1 = round-robin.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles of unacknowledged strobe. Range 2..65535.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  reset: synchronous, active-low. Sampled on the rising edge of `clk`.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  core request.
- `m0_adr_i`  in  ADDR_WIDTH; `m0_dat_i`  in  DATA_WIDTH; `m0_funct3_i`  in  3  core access size.
- `m0_dat_o`  out  DATA_WIDTH; `m0_ack_o`, `m0_err_o`, `m0_stall_o`  out  1 each.
- `m1_*`  same set as M0, for the UART bridge. There is no `m1_funct3_i`: M1 always presents 3'b010 (word) to the slave.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1; `s_adr_o`  out  ADDR_WIDTH; `s_dat_o`  out  DATA_WIDTH; `s_funct3_o`  out  3.
- `s_dat_i`  in  DATA_WIDTH; `s_ack_i`  in  1.
- `owner_o`  out  2  one-hot current owner: [0] = M0, [1] = M1, 00 = idle.

## Operation
- FSM states: IDLE, OWN0, OWN1. Add ABORT when the watchdog is compiled in.
- IDLE:
  - No request pending: stay.
  - One master has `cyc&stb`: go to OWNx.
  - Both request in the same cycle:
    - ARB_MODE 0: go to OWN1.
    - ARB_MODE 1: grant the master that was not served last. The `last` register resets to M1, so M0 wins first.
- OWNx:
  - Slave outputs are a pure mux of master x.
  - `mx_dat_o` = `s_dat_i`, `mx_ack_o` = `s_ack_i`. The other master's ack and err stay 0.
  - Stay while `mx_cyc_i` = 1, so multi-beat UART transfers keep the lock.
  - `mx_cyc_i` = 0 → IDLE and update `last`.
- Stall: `my_stall_o` = 1 whenever `my_cyc_i&my_stb_i` and master y is not the owner, including the IDLE cycle before its grant.
- In IDLE, every `s_*` output is 0 and every `s_dat_o`/`s_adr_o` bit is 0.
- ABORT (watchdog only):
  - `mx_err_o` pulses 1 for one cycle and `s_cyc_o`/`s_stb_o` = 0.
  - Next state is IDLE unconditionally, even if `mx_cyc_i` is still 1.
- Reset values: state IDLE, `owner_o` 00, `last` M1, watchdog count 0. All `*_ack_o`, `*_err_o`, `*_stall_o`, `s_cyc_o`, `s_stb_o`, `s_we_o` are 0 and all data and address outputs are 0. Stall outputs re-evaluate combinationally after reset is released.

## Timing
- Arbitration latency: a request first seen in IDLE at edge N gives ownership and `s_stb_o` = 1 from edge N+1.
- Ack path is combinational, slave to owner, with zero added latency.
- Hand-over: owner drops `cyc` at edge N, the FSM is IDLE in N+1, and the next owner drives the slave from N+2. This guarantees at least one dead cycle between owners.
- Watchdog counter:
  - Increments each cycle in OWNx with `s_stb_o&!s_ack_i`.
  - Clears on ack, on state exit, and on reset.
  - Reaching TIMEOUT_CYCLES-1 moves the FSM to ABORT on the next edge.
- Reset asserted mid-transfer: at the next edge every output returns to its reset value. A pending ack is not forwarded.
- A slave ack seen in IDLE or ABORT is ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined: the watchdog counter, the ABORT state and the `*_err_o` pulses are present.
- Undefined: no counter and no ABORT state, and `m0_err_o` = `m1_err_o` = 0 constantly. An owner that never gets an ack holds the bus indefinitely.

## Structure
- Shared package `osiris_pkg`:
  - owner encoding localparams OWN_NONE / OWN_M0 / OWN_M1.
  - `ARB_FIXED` = 0, `ARB_RR` = 1.
  - `FUNCT3_WORD` = 3'b010.
- One sub-module, `arb_watchdog`, instantiated only under the macro. Its ports are clock, reset, `count_en`, `clear` and `expire`.
- The rest is flat: FSM, `last` register, output muxes.

## Test plan
- **Fixed priority:** ARB_MODE 0, both request in the same cycle with m0 adr 0x10 and m1 adr 0x20 → `s_adr_o` = 0x20 from edge N+1, `m0_stall_o` = 1 until M1 drops `cyc`, then M0 is granted at N+k+2.
- **Round-robin:** ARB_MODE 1, 4 simultaneous request rounds → owner sequence M0, M1, M0, M1.
- **Lock:** M1 holds `cyc` through 3 write beats of 0xA5A5_0001..3 with a single-cycle ack each, while M0 requests → M0 sees no ack, `s_funct3_o` = 3'b010, and M0's `funct3` appears only after M1 releases.
- **Watchdog:** macro on, TIMEOUT_CYCLES 8, slave never acks → `m0_err_o` pulses exactly once, 8 cycles after `stb`, then `s_cyc_o` = 0. With the macro off → `s_cyc_o` stays 1 for 100 cycles and err stays 0.
- **Reset mid-transfer:** `rst` = 0 while in OWN1 with `s_ack_i` = 1 → next cycle `owner_o` = 00, `s_*` = 0, `m1_ack_o` = 0.
- **Spurious ack:** `s_ack_i` = 1 while in IDLE → both `m*_ack_o` stay 0.
